// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the multi-port register file and its scoreboard.
//   Contents:
//     RF_XLEN, RF_NREGS  default data width and register count
//     RF_ZERO_REG        index of the hard-wired zero register
//     rf_state_e         sweep/operate state encoding (RF_CLEAR, RF_READY)
//   No ports; imported by regfile_mp and regfile_scoreboard.
package regfile_pkg;

  localparam int RF_XLEN     = 32;
  localparam int RF_NREGS    = 32;
  localparam int RF_ZERO_REG = 0;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Per-register busy bits used for RAW hazard detection. A register becomes
//   busy when an instruction that writes it issues, and idle when its
//   writeback lands. If both events hit the same register in one cycle the
//   set wins, because the newly issued producer supersedes the retiring one.
//   Register zero is never busy.
//   Ports:
//     clk, rst     clock and asynchronous active-high reset (clears all bits)
//     set_i        mark set_addr_i busy
//     set_addr_i   register being claimed by a new producer
//     clr_i        retire the pending write to clr_addr_i
//     clr_addr_i   register being written back
//     busy_o       current busy vector (state before the coming edge)
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = RF_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_i,
  input  logic [AW-1:0]    set_addr_i,
  input  logic             clr_i,
  input  logic [AW-1:0]    clr_addr_i,
  output logic [NREGS-1:0] busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // next busy vector: set has priority over clear on the same register
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      if (r == RF_ZERO_REG) begin
        busy_d[r] = 1'b0;
      end else if (set_i && (set_addr_i == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (clr_i && (clr_addr_i == AW'(r))) begin
        busy_d[r] = 1'b0;
      end else begin
        busy_d[r] = busy_q[r];
      end
    end
  end

  // busy vector register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= {NREGS{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
//   Parametrised register file: NRD combinational read ports, one synchronous
//   write port, register zero hard-wired to 0, and a busy scoreboard for RAW
//   hazard detection. After reset a sweep zeroes one entry per cycle; the
//   array itself has no reset, so the sweep is the only thing that clears it.
//   ready_o stays low for exactly NREGS cycles after rst deasserts, and while
//   it is low writes/scoreboard sets are dropped and reads return 0/not-busy.
//   Build option:
//     REGFILE_MP_BYPASS_EN  write-first forwarding: a read of the register
//                           being written this cycle returns wd_i and reports
//                           not-busy. Undefined: reads see the stored value.
//   Ports:
//     clk, rst     clock and asynchronous active-high reset
//     rd_addr_i    packed read addresses, port i at [i*AW +: AW]
//     rd_data_o    packed read data, port i at [i*XLEN +: XLEN]
//     rd_busy_o    per-port busy flag of the addressed register
//     we_i, wa_i, wd_i       write port
//     sb_set_i, sb_addr_i    scoreboard claim of a destination register
//     ready_o      high once the clear sweep has finished
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int AW    = $clog2(NREGS),
  parameter int NRD   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]    rd_busy_o,
  input  logic              we_i,
  input  logic [AW-1:0]     wa_i,
  input  logic [XLEN-1:0]   wd_i,
  input  logic              sb_set_i,
  input  logic [AW-1:0]     sb_addr_i,
  output logic              ready_o
);

  localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(RF_ZERO_REG);

  rf_state_e        state_q;
  rf_state_e        state_d;
  logic [AW-1:0]    cnt_q;
  logic [AW-1:0]    cnt_d;

  logic             ready_s;
  logic             arr_we_s;
  logic [AW-1:0]    arr_wa_s;
  logic [XLEN-1:0]  arr_wd_s;
  logic             sb_set_s;
  logic             sb_clr_s;
  logic [NREGS-1:0] busy_s;
  logic             wr_hit_s;

  logic [XLEN-1:0]  mem_q [NREGS];

  // state and sweep counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RF_CLEAR;
      cnt_q   <= {AW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: the last sweep entry is written in the cycle that leaves CLEAR
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = RF_READY;
          cnt_d   = {AW{1'b0}};
        end else begin
          state_d = RF_CLEAR;
          cnt_d   = cnt_q + AW'(1);
        end
      end
      RF_READY: begin
        state_d = RF_READY;
        cnt_d   = cnt_q;
      end
      default: begin
        state_d = RF_CLEAR;
        cnt_d   = {AW{1'b0}};
      end
    endcase
  end

  // outputs per state: array write source and gated scoreboard controls
  always_comb begin
    ready_s  = 1'b0;
    arr_we_s = 1'b0;
    arr_wa_s = cnt_q;
    arr_wd_s = {XLEN{1'b0}};
    sb_set_s = 1'b0;
    sb_clr_s = 1'b0;
    case (state_q)
      RF_CLEAR: begin
        arr_we_s = 1'b1;
        arr_wa_s = cnt_q;
        arr_wd_s = {XLEN{1'b0}};
      end
      RF_READY: begin
        ready_s  = 1'b1;
        arr_we_s = we_i && (wa_i != ZERO_ADDR);
        arr_wa_s = wa_i;
        arr_wd_s = wd_i;
        sb_set_s = sb_set_i && (sb_addr_i != ZERO_ADDR);
        sb_clr_s = we_i;
      end
      default: begin
        ready_s  = 1'b0;
        arr_we_s = 1'b0;
      end
    endcase
  end

  assign ready_o = ready_s;

  // storage array; deliberately no reset, the sweep zeroes it
  always_ff @(posedge clk) begin
    if (arr_we_s) begin
      mem_q[arr_wa_s] <= arr_wd_s;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_i      (sb_set_s),
    .set_addr_i (sb_addr_i),
    .clr_i      (sb_clr_s),
    .clr_addr_i (wa_i),
    .busy_o     (busy_s)
  );

`ifdef REGFILE_MP_BYPASS_EN
  assign wr_hit_s = we_i && (wa_i != ZERO_ADDR);
`else
  assign wr_hit_s = 1'b0;
`endif

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   ra_s;
    logic [XLEN-1:0] rdat_s;
    logic            rbusy_s;

    assign ra_s = rd_addr_i[gi*AW +: AW];

    // read mux: forced idle during the sweep, optional write-first forwarding
    always_comb begin
      rdat_s  = {XLEN{1'b0}};
      rbusy_s = 1'b0;
      if (state_q != RF_READY) begin
        rdat_s  = {XLEN{1'b0}};
        rbusy_s = 1'b0;
      end else if (wr_hit_s && (ra_s == wa_i)) begin
        rdat_s  = wd_i;
        rbusy_s = 1'b0;
      end else if (ra_s == ZERO_ADDR) begin
        rdat_s  = {XLEN{1'b0}};
        rbusy_s = 1'b0;
      end else begin
        rdat_s  = mem_q[ra_s];
        rbusy_s = busy_s[ra_s];
      end
    end

    assign rd_data_o[gi*XLEN +: XLEN] = rdat_s;
    assign rd_busy_o[gi]              = rbusy_s;
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // default configuration: XLEN=32, NREGS=32, NRD=2
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic        ready;

  // wide configuration: XLEN=64, NREGS=16, NRD=4
  logic         rst2;
  logic [15:0]  rd_addr2;
  logic [255:0] rd_data2;
  logic [3:0]   rd_busy2;
  logic         we2;
  logic [3:0]   wa2;
  logic [63:0]  wd2;
  logic         sb_set2;
  logic [3:0]   sb_addr2;
  logic         ready2;

  regfile_mp dut (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .rd_busy_o(rd_busy), .we_i(we), .wa_i(wa), .wd_i(wd),
    .sb_set_i(sb_set), .sb_addr_i(sb_addr), .ready_o(ready)
  );

  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(4)) dut2 (
    .clk(clk), .rst(rst2), .rd_addr_i(rd_addr2), .rd_data_o(rd_data2),
    .rd_busy_o(rd_busy2), .we_i(we2), .wa_i(wa2), .wd_i(wd2),
    .sb_set_i(sb_set2), .sb_addr_i(sb_addr2), .ready_o(ready2)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        sb;
    logic [4:0]  sa;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        b0;
    logic        b1;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  localparam logic [63:0] BASE2 = 64'h0123_4567_89AB_CDEF;

  function automatic vec_t mk(input logic w, input logic [4:0] a, input logic [31:0] d,
                              input logic s, input logic [4:0] sa,
                              input logic [4:0] r0, input logic [4:0] r1,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic eb0, input logic eb1);
    vec_t v;
    v.we = w; v.wa = a; v.wd = d; v.sb = s; v.sa = sa;
    v.a0 = r0; v.a1 = r1; v.d0 = e0; v.d1 = e1; v.b0 = eb0; v.b1 = eb1;
    return v;
  endfunction

  function automatic logic [63:0] exp2(input int a);
    if (a == 0) return 64'd0;
    return BASE2 ^ 64'(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts rising edges after rst release until ready; optionally injects a
  // write + scoreboard set to x5 mid-sweep that must be dropped.
  task automatic sweep_wait(input int exp_cyc, input bit inject);
    int cyc;
    cyc = 0;
    while (cyc < 64) begin
      @(posedge clk);
      #1;
      cyc++;
      if (ready) break;
      if (cyc == 2) chk("sweep_rd_forced0", {32'd0, rd_data[31:0]}, 64'd0);
      if (inject && cyc == 20) begin
        we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; sb_set = 1'b1; sb_addr = 5'd5;
      end else begin
        we = 1'b0; sb_set = 1'b0;
      end
    end
    we = 1'b0; sb_set = 1'b0;
    chk("sweep_len", 64'(cyc), 64'(exp_cyc));
  endtask

  initial begin
    logic [31:0] e0, e1;
    logic        eb0, eb1;
    int          cyc;
    int          sets [3][4];

    rst = 1'b1; rd_addr = {5'd5, 5'd31}; we = 1'b0; wa = 5'd0; wd = 32'd0;
    sb_set = 1'b0; sb_addr = 5'd0;
    rst2 = 1'b1; rd_addr2 = 16'd0; we2 = 1'b0; wa2 = 4'd0; wd2 = 64'd0;
    sb_set2 = 1'b0; sb_addr2 = 4'd0;

    //   we  wa     wd            sb  sa     a0     a1     d0            d1            b0    b1
    tbl[0]  = mk(1'b1, 5'd5,  32'h1234_5678, 1'b0, 5'd0,  5'd5,  5'd0,  32'h0,         32'h0,         1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd5,  5'd0,  32'h1234_5678, 32'h0,         1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 5'd0,  5'd0,  5'd5,  32'h0,         32'h1234_5678, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  5'd7,  5'd7,  32'h0,         32'h0,         1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd7,  5'd5,  32'h0,         32'h1234_5678, 1'b1, 1'b0);
    tbl[6]  = mk(1'b1, 5'd7,  32'hA5,        1'b0, 5'd0,  5'd7,  5'd7,  32'h0,         32'h0,         1'b1, 1'b1);
    tbl[7]  = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd7,  5'd7,  32'hA5,        32'hA5,        1'b0, 1'b0);
    tbl[8]  = mk(1'b1, 5'd7,  32'h5A,        1'b1, 5'd7,  5'd7,  5'd5,  32'hA5,        32'h1234_5678, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd7,  5'd7,  32'h5A,        32'h5A,        1'b1, 1'b1);
    tbl[10] = mk(1'b1, 5'd3,  32'h55,        1'b0, 5'd0,  5'd3,  5'd7,  32'h0,         32'h5A,        1'b0, 1'b1);
    tbl[11] = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd3,  5'd3,  32'h55,        32'h55,        1'b0, 1'b0);
    tbl[12] = mk(1'b1, 5'd7,  32'h77,        1'b1, 5'd2,  5'd2,  5'd7,  32'h0,         32'h5A,        1'b0, 1'b1);
    tbl[13] = mk(1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  5'd2,  5'd7,  32'h0,         32'h77,        1'b1, 1'b0);
    tbl[14] = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd0,  5'd2,  32'h0,         32'h0,         1'b0, 1'b1);
    tbl[15] = mk(1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 5'd0,  5'd31, 5'd30, 32'h0,         32'h0,         1'b0, 1'b0);
    tbl[16] = mk(1'b0, 5'd0,  32'h0,         1'b1, 5'd31, 5'd31, 5'd2,  32'hFFFF_FFFF, 32'h0,         1'b0, 1'b1);
    tbl[17] = mk(1'b1, 5'd2,  32'h22,        1'b0, 5'd0,  5'd31, 5'd2,  32'hFFFF_FFFF, 32'h0,         1'b1, 1'b1);
    tbl[18] = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd2,  5'd31, 32'h22,        32'hFFFF_FFFF, 1'b0, 1'b1);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {63'd0, ready}, 64'd0);
    chk("rst_busy", {62'd0, rd_busy}, 64'd0);
    chk("rst_rdata", rd_data, 64'd0);

    // first sweep with a write/scoreboard set issued mid-sweep
    @(negedge clk);
    rst = 1'b0;
    sweep_wait(32, 1'b1);
    chk("ready_after_sweep", {63'd0, ready}, 64'd1);
    @(negedge clk);
    rd_addr = {5'd0, 5'd5};
    #1;
    chk("sweep_write_dropped", {32'd0, rd_data[31:0]}, 64'd0);
    chk("sweep_sbset_dropped", {63'd0, rd_busy[0]}, 64'd0);

    // directed vector table
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
      sb_set = tbl[i].sb; sb_addr = tbl[i].sa;
      rd_addr = {tbl[i].a1, tbl[i].a0};
      e0 = tbl[i].d0; e1 = tbl[i].d1; eb0 = tbl[i].b0; eb1 = tbl[i].b1;
`ifdef REGFILE_MP_BYPASS_EN
      if (tbl[i].we && tbl[i].wa != 5'd0 && tbl[i].a0 == tbl[i].wa) begin
        e0 = tbl[i].wd; eb0 = 1'b0;
      end
      if (tbl[i].we && tbl[i].wa != 5'd0 && tbl[i].a1 == tbl[i].wa) begin
        e1 = tbl[i].wd; eb1 = 1'b0;
      end
`endif
      #1;
      chk($sformatf("v%0d_d0", i), {32'd0, rd_data[31:0]}, {32'd0, e0});
      chk($sformatf("v%0d_d1", i), {32'd0, rd_data[63:32]}, {32'd0, e1});
      chk($sformatf("v%0d_b0", i), {63'd0, rd_busy[0]}, {63'd0, eb0});
      chk($sformatf("v%0d_b1", i), {63'd0, rd_busy[1]}, {63'd0, eb1});
    end
    @(negedge clk);
    we = 1'b0; sb_set = 1'b0;

    // fill every register, mark x9 busy, then reset in mid-operation
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      we = 1'b1; wa = 5'(r); wd = 32'hA000_0000 | 32'(r);
    end
    @(negedge clk);
    we = 1'b0; sb_set = 1'b1; sb_addr = 5'd9;
    @(negedge clk);
    sb_set = 1'b0; rd_addr = {5'd31, 5'd9};
    #1;
    chk("fill_x9", {32'd0, rd_data[31:0]}, 64'hA000_0009);
    chk("fill_x31", {32'd0, rd_data[63:32]}, 64'hA000_001F);
    chk("busy_x9_set", {63'd0, rd_busy[0]}, 64'd1);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_ready_drop", {63'd0, ready}, 64'd0);
    chk("midrst_busy_forced", {62'd0, rd_busy}, 64'd0);
    chk("midrst_rdata_forced", rd_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rd_addr = {5'd9, 5'd31};
    sweep_wait(32, 1'b0);
    for (int r = 0; r < 32; r += 2) begin
      @(negedge clk);
      rd_addr = {5'(r + 1), 5'(r)};
      #1;
      chk($sformatf("clr_x%0d", r), {32'd0, rd_data[31:0]}, 64'd0);
      chk($sformatf("clr_x%0d", r + 1), {32'd0, rd_data[63:32]}, 64'd0);
      chk($sformatf("clr_busy_x%0d", r), {62'd0, rd_busy}, 64'd0);
    end

    // wide configuration: 16-entry sweep, 4 ports, 64-bit data
    @(negedge clk);
    rst2 = 1'b0;
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (ready2) break;
    end
    chk("p_sweep_len", 64'(cyc), 64'd16);
    for (int r = 1; r < 16; r++) begin
      @(negedge clk);
      we2 = 1'b1; wa2 = 4'(r); wd2 = BASE2 ^ 64'(r);
    end
    @(negedge clk);
    we2 = 1'b0;
    sets = '{'{0, 1, 2, 3}, '{15, 9, 4, 7}, '{8, 8, 14, 5}};
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      rd_addr2 = {4'(sets[s][3]), 4'(sets[s][2]), 4'(sets[s][1]), 4'(sets[s][0])};
      #1;
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("p_set%0d_port%0d", s, p), rd_data2[p*64 +: 64], exp2(sets[s][p]));
      end
    end
    @(negedge clk);
    sb_set2 = 1'b1; sb_addr2 = 4'd12;
    @(negedge clk);
    sb_set2 = 1'b0;
    rd_addr2 = {4'd12, 4'd3, 4'd0, 4'd12};
    #1;
    chk("p_busy_ports", {60'd0, rd_busy2}, 64'h9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the integer register file.
- Configurable data width, register count and number of combinational read ports; one synchronous write port.
- After reset, a sequential clear sweep zeroes the array; `ready` is held low until the sweep completes.
- Adds a per-register busy scoreboard so the decode stage can detect RAW hazards against in-flight writebacks.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- AW, $clog2(NREGS), register address width (derived).
- NRD, 2, number of read ports, 1 to 4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- rd_addr  in  NRD*AW  packed read addresses; port i uses bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  packed read data, combinational from rd_addr.
- rd_busy  out  NRD  per-port: the addressed register has a pending write.
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  XLEN  write data.
- sb_set  in  1  mark register sb_addr as pending (instruction issued).
- sb_addr  in  AW  scoreboard set address.
- ready  out  1  high once the clear sweep is done.

Behaviour:
- State machine: CLEAR and READY.
  - rst asserted (asynchronous) forces CLEAR, sweep counter to 0, busy vector to 0, ready to 0.
- CLEAR:
  - Each cycle writes 0 to entry counter, then increments the counter.
  - When the counter reaches NREGS-1, that entry is written and the next state is READY.
  - The sweep therefore takes exactly NREGS cycles after rst deasserts.
  - we and sb_set are ignored; writes are dropped, not queued.
  - rd_data is forced to 0 and rd_busy to 0.
- READY:
  - ready = 1.
  - Write takes effect at the rising edge when we=1 and wa!=0; data is visible to reads in the next cycle.
- Register 0:
  - Always reads 0; writes to it are discarded.
  - Never marked busy; sb_set with sb_addr=0 is ignored.
- Reads:
  - Zero-cycle latency; purely combinational in addr.
  - Multiple ports may read the same address.
- Scoreboard:
  - busy[sb_addr] is set on sb_set.
  - busy[wa] is cleared on we.
  - Same address, same cycle, set and clear: set wins (a new producer supersedes the retiring one).
  - Different addresses update independently.
  - rd_busy[i] = busy[rd_addr[i]]; it reflects state before the current edge.
  - A write to a non-busy register is legal and leaves busy unchanged.
- rst mid-sweep or mid-operation: immediately returns to CLEAR, restarts the sweep from 0, and clears busy.
- Array contents are not reset asynchronously; only the sweep zeroes them.
- Width rules:
  - wd is stored verbatim, with no extension.
  - Addresses at or above NREGS cannot occur (AW is exact).

Optional Feature:
- Macro name: REGFILE_MP_BYPASS_EN.
- Defined: write-first forwarding.
  - If we=1, wa!=0, state is READY and rd_addr[i]==wa, then rd_data[i]=wd in the same cycle.
  - rd_busy[i] is forced to 0 for that port in that cycle.
- Undefined: read-old behaviour; rd_data returns the stored value until after the edge, and rd_busy reflects the stored busy bit.

Decomposition:
- Shared package regfile_pkg holds:
  - the state enum (RF_CLEAR, RF_READY);
  - default constants RF_XLEN=32 and RF_NREGS=32;
  - the register-zero address constant.
- Natural sub-module: regfile_scoreboard, containing the busy vector and its set/clear priority logic, with the same clk/rst.
- The array and sweep FSM stay in the top module.

Test Plan:
1. Reset then sweep:
   - Pulse rst, release, count cycles.
   - ready rises exactly 32 cycles after release.
   - All 32 registers read 0; a write of 0xDEADBEEF issued during the sweep is dropped.
2. Write and read:
   - Write x5=0x12345678.
   - Next cycle, port 0 reads x5 = 0x12345678 and port 1 reads x0 = 0.
   - Write x0=0xFFFFFFFF; x0 still reads 0.
3. Scoreboard:
   - sb_set x7; next cycle rd_busy for x7 = 1.
   - we x7=0xA5; next cycle rd_busy = 0.
   - sb_set x7 and we x7 in the same cycle leave rd_busy = 1.
4. Bypass:
   - With REGFILE_MP_BYPASS_EN, we x3=0x55 while reading x3: same cycle rd_data=0x55, rd_busy=0.
   - Without the macro: same cycle returns the old value, next cycle returns 0x55.
5. Reset mid-operation:
   - Set x9=0x99 and busy x9; assert rst for 1 cycle at cycle 10 of operation.
   - ready drops immediately and busy clears.
   - After 32 cycles x9 reads 0.
6. Parameter sweep:
   - NREGS=16, NRD=4, XLEN=64.
   - Sweep takes 16 cycles.
   - All 4 ports read distinct registers correctly after writes of 0x0123456789ABCDEF.
